// File: rtl/bus_seq_pkg.sv
// Shared types and default widths for the bus master transfer sequencer.
package bus_seq_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned LW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Command payload at default widths (agents/benches build commands with it)
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
        logic              wen;
        logic [LW_DEF-1:0] len;
    } cmd_t;

endpackage

// File: rtl/bus_master_seq_if.sv
// Master-port bus signals between the sequencer and the bus top.
interface bus_master_seq_if #(
    parameter int unsigned AW = bus_seq_pkg::AW_DEF,
    parameter int unsigned DW = bus_seq_pkg::DW_DEF
);
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic          wen;
    logic          mwvalid;
    logic          mready;
    logic [DW-1:0] mrdata;

    modport master (output maddr, output mwdata, output wen, output mwvalid,
                    input mready, input mrdata);
    modport slave  (input maddr, input mwdata, input wen, input mwvalid,
                    output mready, output mrdata);
endinterface

// File: rtl/bus_seq_cmd_fifo.sv
// Synchronous command FIFO with registered not_full/empty flags.
module bus_seq_cmd_fifo
    import bus_seq_pkg::*;
#(
    parameter int unsigned W     = 29,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head_c,
    output logic         not_full,
    output logic         empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          not_full_q, not_full_d, empty_q, empty_d;
    logic          do_push, do_pop;

    // Pointer/occupancy update; flags derived from the next count so they are flops
    always_comb begin
        do_push = push && not_full_q;
        do_pop  = pop && !empty_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != CW'(DEPTH));
        empty_d    = (count_d == '0);
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
            empty_q    <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
            empty_q    <= empty_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign head_c   = mem_q[rptr_q];
    assign not_full = not_full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/bus_master_seq.sv
// Master-side transfer sequencer: queued commands -> bus beats -> per-beat responses.
module bus_master_seq
    import bus_seq_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LW      = LW_DEF,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic          cmd_wen,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_last,
    bus_master_seq_if.master bus
);
    localparam int unsigned CW  = AW + DW + 1 + LW;
    localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wen;
        logic [LW-1:0] len;
    } cmd_w_t;

    cmd_w_t cmd_in, cmd_head;
    logic   fifo_not_full, fifo_empty, pop_c;

    state_e         state_q, state_d;
    logic [AW-1:0]  maddr_q, maddr_d;
    logic [DW-1:0]  mwdata_q, mwdata_d;
    logic           wen_q, wen_d, mwvalid_q, mwvalid_d;
    logic [LW-1:0]  beats_q, beats_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [TCW-1:0] wait_q, wait_d;
    logic           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;

    // Pack the incoming command for the queue
    always_comb begin
        cmd_in.addr  = cmd_addr;
        cmd_in.wdata = cmd_wdata;
        cmd_in.wen   = cmd_wen;
        cmd_in.len   = cmd_len;
    end

    bus_seq_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (cmd_valid),
        .wdata    (cmd_in),
        .pop      (pop_c),
        .head_c   (cmd_head),
        .not_full (fifo_not_full),
        .empty    (fifo_empty)
    );

    // Next-state and output decode; WAIT lasts at most TIMEOUT-1 cycles so an
    // unanswered beat responds SETTLE+TIMEOUT cycles after its pulse
    always_comb begin
        state_d     = state_q;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;
        wen_d       = wen_q;
        mwvalid_d   = 1'b0;
        beats_d     = beats_q;
        settle_d    = settle_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        rsp_rdata_d = rsp_rdata_q;
        pop_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.mready) begin
                    pop_c     = 1'b1;
                    maddr_d   = cmd_head.addr;
                    wen_d     = cmd_head.wen;
                    mwdata_d  = cmd_head.wen ? cmd_head.wdata : '0;
                    beats_d   = cmd_head.len;
                    mwvalid_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SCW'(SETTLE - 1)) begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            ST_WAIT: begin
                if (bus.mready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wen_q ? '0 : bus.mrdata;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = (beats_q == '0);
                    state_d     = ST_RESP;
                end else if (wait_q == TCW'(TIMEOUT - 2)) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_d = wait_q + TCW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid_q) begin
                    if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        if (rsp_last_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            maddr_d = maddr_q + AW'(1);
                            beats_d = beats_q - LW'(1);
                            if (bus.mready) begin
                                mwvalid_d = 1'b1;
                                state_d   = ST_ISSUE;
                            end
                        end
                    end
                end else if (bus.mready) begin
                    // beat already accepted; stalled for the bus to go idle
                    mwvalid_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transfer silently
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            maddr_q     <= '0;
            mwdata_q    <= '0;
            wen_q       <= 1'b0;
            mwvalid_q   <= 1'b0;
            beats_q     <= '0;
            settle_q    <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
            wen_q       <= wen_d;
            mwvalid_q   <= mwvalid_d;
            beats_q     <= beats_d;
            settle_q    <= settle_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready   = fifo_not_full;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_last    = rsp_last_q;
    assign bus.maddr   = maddr_q;
    assign bus.mwdata  = mwdata_q;
    assign bus.wen     = wen_q;
    assign bus.mwvalid = mwvalid_q;

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq with a simple memory-backed bus slave.
module tb_bus_master_seq;
    import bus_seq_pkg::*;

    localparam int unsigned AW = 16, DW = 8, DEPTH = 4, LW = 4, SETTLE = 4, TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, cmd_valid, cmd_ready, cmd_wen;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [DW-1:0] rsp_rdata;
    logic          mready_tb;

    bus_master_seq_if #(.AW(AW), .DW(DW)) bus ();

    bus_master_seq #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LW(LW), .SETTLE(SETTLE),
                     .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wen(cmd_wen), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .bus(bus)
    );

    // Bus slave: memory written on write pulses, read combinationally
    logic [DW-1:0] mem [2**AW];
    assign bus.mready = mready_tb;
    assign bus.mrdata = mem[bus.maddr];
    always @(posedge clk) if (bus.mwvalid && bus.wen) mem[bus.maddr] <= bus.mwdata;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wen; logic [31:0] cyc; } pulse_t;
    typedef struct packed { logic [DW-1:0] rdata; logic err; logic last; logic [31:0] cyc; } rsp_rec_t;
    typedef struct { cmd_t cmd; logic [DW-1:0] exp_mwdata; logic [DW-1:0] exp_rdata; } vec_t;

    pulse_t      pulse_q [$];
    rsp_rec_t    rsp_q [$];
    logic [31:0] cyc = 0;
    int          n_checks = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record request pulses and accepted responses mid-cycle
    always @(negedge clk) begin
        pulse_t   p;
        rsp_rec_t r;
        if (rstn) begin
            if (bus.mwvalid) begin
                p.addr = bus.maddr; p.wdata = bus.mwdata; p.wen = bus.wen; p.cyc = cyc;
                pulse_q.push_back(p);
            end
            if (rsp_valid && rsp_ready) begin
                r.rdata = rsp_rdata; r.err = rsp_err; r.last = rsp_last; r.cyc = cyc;
                rsp_q.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic w, input logic [LW-1:0] l);
        cmd_t c;
        c.addr = a; c.wdata = d; c.wen = w; c.len = l;
        return c;
    endfunction

    task automatic push(input cmd_t c);
        int n = 0;
        cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_wen = c.wen; cmd_len = c.len;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin tick(); n++; end
        chk("push_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int k = 0;
        while (rsp_q.size() < n && k < budget) begin tick(); k++; end
        chk(name, 32'(rsp_q.size()), 32'(n));
    endtask

    task automatic wait_pulse(input string name);
        int k = 0;
        while (!bus.mwvalid && k < 50) begin tick(); k++; end
        chk(name, 32'(bus.mwvalid), 32'd1);
    endtask

    vec_t        vecs [8];
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_rd [5];
    logic [AW-1:0] exp_pa [5];
    logic [DW+1:0] held;
    int          hold_bad, pulses_before;
    logic        go;

    initial begin
        vecs[0] = '{mk(16'h0ABC, 8'h55, 1'b1, 4'd0), 8'h55, 8'h00};
        vecs[1] = '{mk(16'h02C5, 8'h34, 1'b1, 4'd0), 8'h34, 8'h00};
        vecs[2] = '{mk(16'h0ABC, 8'hEE, 1'b0, 4'd0), 8'h00, 8'h55};
        vecs[3] = '{mk(16'h02C5, 8'hEE, 1'b0, 4'd0), 8'h00, 8'h34};
        vecs[4] = '{mk(16'h1234, 8'hC3, 1'b1, 4'd0), 8'hC3, 8'h00};
        vecs[5] = '{mk(16'h1234, 8'h00, 1'b0, 4'd0), 8'h00, 8'hC3};
        vecs[6] = '{mk(16'h7FFF, 8'h0F, 1'b1, 4'd0), 8'h0F, 8'h00};
        vecs[7] = '{mk(16'h7FFF, 8'h99, 1'b0, 4'd0), 8'h00, 8'h0F};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wen = 1'b0;
        cmd_len = '0; rsp_ready = 1'b1; mready_tb = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mwvalid", 32'(bus.mwvalid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_maddr", 32'(bus.maddr), 32'd0);
        chk("rst_wen_mwdata", 32'({bus.wen, bus.mwdata}), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_err, rsp_last, rsp_rdata}), 32'd0);
        rstn = 1'b1;
        tick();

        // Single-beat commands queued back-to-back
        foreach (vecs[i]) push(vecs[i].cmd);
        wait_rsp(8, 300, "table_rsp_count");
        chk("table_pulse_count", 32'(pulse_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_maddr", i), 32'(pulse_q[i].addr), 32'(vecs[i].cmd.addr));
            chk($sformatf("v%0d_mwdata", i), 32'(pulse_q[i].wdata), 32'(vecs[i].exp_mwdata));
            chk($sformatf("v%0d_wen", i), 32'(pulse_q[i].wen), 32'(vecs[i].cmd.wen));
            chk($sformatf("v%0d_rdata", i), 32'(rsp_q[i].rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_err_last", i), 32'({rsp_q[i].err, rsp_q[i].last}), 32'b01);
            chk($sformatf("v%0d_latency", i), rsp_q[i].cyc - pulse_q[i].cyc, 32'd6);
            if (i > 0) chk($sformatf("v%0d_spacing", i), pulse_q[i].cyc - pulse_q[i-1].cyc, 32'd8);
        end

        // Write burst wrapping the address space
        pulse_q.delete(); rsp_q.delete();
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        push(mk(16'hFFFE, 8'hA5, 1'b1, 4'd3));
        wait_rsp(4, 200, "bw_rsp_count");
        chk("bw_pulse_count", 32'(pulse_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bw%0d_maddr", i), 32'(pulse_q[i].addr), 32'(exp_a[i]));
            chk($sformatf("bw%0d_wdata_wen", i), 32'({pulse_q[i].wdata, pulse_q[i].wen}), 32'h14B);
            chk($sformatf("bw%0d_rsp", i), 32'({rsp_q[i].rdata, rsp_q[i].err, rsp_q[i].last}),
                32'((i == 3) ? 1 : 0));
            if (i > 0) chk($sformatf("bw%0d_spacing", i), pulse_q[i].cyc - pulse_q[i-1].cyc, 32'd7);
        end

        // Read burst over the same wrapped region
        pulse_q.delete(); rsp_q.delete();
        push(mk(16'hFFFF, 8'h11, 1'b0, 4'd2));
        wait_rsp(3, 200, "br_rsp_count");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("br%0d_maddr", i), 32'(pulse_q[i].addr), 32'(exp_a[i+1]));
            chk($sformatf("br%0d_wdata_wen", i), 32'({pulse_q[i].wdata, pulse_q[i].wen}), 32'd0);
            chk($sformatf("br%0d_rsp", i), 32'({rsp_q[i].rdata, rsp_q[i].err, rsp_q[i].last}),
                32'({8'hA5, 1'b0, (i == 2)}));
        end

        // Timeout on beat 0 of a 3-beat read drops the remaining beats
        pulse_q.delete(); rsp_q.delete();
        push(mk(16'h0100, 8'h00, 1'b0, 4'd2));
        wait_pulse("to_pulse_seen");
        mready_tb = 1'b0;
        wait_rsp(1, 150, "to_rsp_count");
        chk("to_rsp", 32'({rsp_q[0].rdata, rsp_q[0].err, rsp_q[0].last}), 32'b11);
        chk("to_latency", rsp_q[0].cyc - pulse_q[0].cyc, 32'(SETTLE + TIMEOUT));
        mready_tb = 1'b1;
        repeat (40) tick();
        chk("to_no_more_pulses", 32'(pulse_q.size()), 32'd1);
        chk("to_no_more_rsp", 32'(rsp_q.size()), 32'd1);

        // Queue fill behind a stuck beat, then response back-pressure
        pulse_q.delete(); rsp_q.delete();
        rsp_ready = 1'b0;
        push(mk(16'h0ABC, 8'h00, 1'b0, 4'd0));
        wait_pulse("fill_pulse_seen");
        mready_tb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin cmd_addr = 16'h02C5; cmd_wdata = 8'h00; cmd_wen = 1'b0; end
                1: begin cmd_addr = 16'h0300; cmd_wdata = 8'h77; cmd_wen = 1'b1; end
                2: begin cmd_addr = 16'h0300; cmd_wdata = 8'h00; cmd_wen = 1'b0; end
                default: begin cmd_addr = 16'h0ABC; cmd_wdata = 8'h00; cmd_wen = 1'b0; end
            endcase
            cmd_len = '0; cmd_valid = 1'b1;
            chk($sformatf("fill_ready%0d", i), 32'(cmd_ready), 32'd1);
            tick();
        end
        chk("fill_full", 32'(cmd_ready), 32'd0);
        cmd_addr = 16'h0ABC; cmd_wdata = 8'h00; cmd_wen = 1'b0;
        repeat (5) tick();
        chk("fill_stall", 32'(cmd_ready), 32'd0);
        for (int k = 0; k < 150 && !rsp_valid; k++) tick();
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp_err", 32'(rsp_err), 32'd1);
        mready_tb = 1'b1;
        held = {rsp_rdata, rsp_err, rsp_last};
        pulses_before = pulse_q.size();
        hold_bad = 0;
        repeat (20) begin
            tick();
            if (!rsp_valid || {rsp_rdata, rsp_err, rsp_last} != held) hold_bad++;
        end
        chk("hold_payload", 32'(hold_bad), 32'd0);
        chk("hold_no_pulse", 32'(pulse_q.size()), 32'(pulses_before));
        rsp_ready = 1'b1;
        for (int k = 0; k < 400 && rsp_q.size() < 5; k++) begin
            go = cmd_valid && cmd_ready;
            tick();
            if (go) cmd_valid = 1'b0;
        end
        chk("fill_rsp_count", 32'(rsp_q.size()), 32'd5);
        chk("fill_pulse_count", 32'(pulse_q.size()), 32'd5);
        chk("fill_rsp0", 32'({rsp_q[0].rdata, rsp_q[0].err, rsp_q[0].last}), 32'b11);
        exp_rd = '{8'h00, 8'h34, 8'h00, 8'h77, 8'h55};
        exp_pa = '{16'h0ABC, 16'h02C5, 16'h0300, 16'h0300, 16'h0ABC};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_maddr", i), 32'(pulse_q[i].addr), 32'(exp_pa[i]));
            if (i > 0) chk($sformatf("fill%0d_rsp", i),
                           32'({rsp_q[i].rdata, rsp_q[i].err, rsp_q[i].last}),
                           32'({exp_rd[i], 1'b0, 1'b1}));
        end

        // Reset while a read sits in WAIT with another command queued
        pulse_q.delete(); rsp_q.delete();
        push(mk(16'h02C5, 8'h00, 1'b0, 4'd0));
        wait_pulse("rst_pulse_seen");
        mready_tb = 1'b0;
        push(mk(16'h0400, 8'h99, 1'b1, 4'd0));
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        chk("mid_rst_mwvalid", 32'(bus.mwvalid), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rstn = 1'b1; mready_tb = 1'b1;
        pulse_q.delete(); rsp_q.delete();
        repeat (20) tick();
        chk("mid_rst_queue_empty", 32'(pulse_q.size()), 32'd0);
        chk("mid_rst_no_rsp", 32'(rsp_q.size()), 32'd0);
        push(mk(16'h02C5, 8'h00, 1'b0, 4'd0));
        wait_rsp(1, 100, "post_rst_rsp_count");
        chk("post_rst_maddr", 32'(pulse_q[0].addr), 32'h02C5);
        chk("post_rst_rsp", 32'({rsp_q[0].rdata, rsp_q[0].err, rsp_q[0].last}), 32'({8'h34, 2'b01}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
